hwpe_stream_sink_byte_realign: RTL and testbench



---
 rtl/hwpe_stream_sink_byte_realign.sv | 174 +++++++++++++++++
 tb/tb_hwpe_stream_sink_byte_realign.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_sink_byte_realign.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_stream_sink_byte_realign
// Brief    : Rotates a word-aligned HWPE stream onto a misaligned byte offset
//            for a TCDM sink streamer, adding a flush word for residual bytes.
//            Optional output register: HWPE_STREAM_SINK_REALIGN_OUT_REG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_stream_sink_byte_realign #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    localparam int NB        = DATA_WIDTH / 8,
    localparam int OFFW      = $clog2(NB)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  realign_i,
    input  logic [OFFW-1:0]       offset_i,
    input  logic [LEN_WIDTH-1:0]  line_length_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic [NB-1:0]         push_strb_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic [NB-1:0]         pop_strb_o,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [OFFW:0] C_NB = (OFFW + 1)'(NB);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_MID   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_realign;
    logic [OFFW-1:0]        r_off;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_cnt;
    logic [DATA_WIDTH-1:0]  r_res_data;
    logic [NB-1:0]          r_res_strb;
    logic                   r_done_zero;

    logic                   w_in_phase;
    logic [OFFW-1:0]        w_koff;
    logic [OFFW:0]          w_res_sh;
    logic [DATA_WIDTH-1:0]  w_hi_data;
    logic [NB-1:0]          w_hi_strb;
    logic [DATA_WIDTH-1:0]  w_lo_data;
    logic [NB-1:0]          w_lo_strb;
    logic                   w_last_in;
    logic                   w_dp_valid;
    logic                   w_dp_ready;
    logic                   w_dp_fire;
    logic                   w_dp_last;
    logic [DATA_WIDTH-1:0]  w_dp_data;
    logic [NB-1:0]          w_dp_strb;
    logic                   w_start_ok;

    assign w_in_phase = (r_state == S_FIRST) || (r_state == S_MID);
    assign w_koff     = r_realign ? r_off : '0;
    assign w_res_sh   = C_NB - {1'b0, w_koff};

    // Residual is masked in FIRST so stale bytes of a previous line never leak out
    assign w_hi_data = w_in_phase ? push_data_i : '0;
    assign w_hi_strb = w_in_phase ? push_strb_i : '0;
    assign w_lo_data = ((r_state == S_MID) || (r_state == S_FLUSH)) ? r_res_data : '0;
    assign w_lo_strb = ((r_state == S_MID) || (r_state == S_FLUSH)) ? r_res_strb : '0;

    assign w_dp_data = (w_hi_data << {w_koff, 3'b000}) | (w_lo_data >> {w_res_sh, 3'b000});
    assign w_dp_strb = (w_hi_strb << w_koff) | (w_lo_strb >> w_res_sh);

    assign w_last_in  = ((r_cnt + LEN_WIDTH'(1)) == r_len);
    assign w_dp_valid = w_in_phase ? push_valid_i : (r_state == S_FLUSH);
    assign w_dp_last  = (r_state == S_FLUSH) || (w_in_phase && w_last_in && (w_koff == '0));
    assign w_dp_fire  = w_dp_valid && w_dp_ready;

    assign push_ready_o = w_in_phase && w_dp_ready;

`ifdef HWPE_STREAM_SINK_REALIGN_OUT_REG_EN
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [NB-1:0]         r_out_strb;

    assign w_dp_ready = ~r_out_valid | pop_ready_i;
    assign w_start_ok = ~r_out_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_strb  <= '0;
        end else if (w_dp_ready) begin
            r_out_valid <= w_dp_valid;
            r_out_last  <= w_dp_last;
            r_out_data  <= w_dp_data;
            r_out_strb  <= w_dp_strb;
        end
    end

    assign pop_valid_o = r_out_valid;
    assign pop_data_o  = r_out_data;
    assign pop_strb_o  = r_out_strb;
    assign done_o      = r_done_zero | (r_out_valid & pop_ready_i & r_out_last);
    assign busy_o      = (r_state != S_IDLE) | r_out_valid;
`else
    assign w_dp_ready  = pop_ready_i;
    assign w_start_ok  = 1'b1;
    assign pop_valid_o = w_dp_valid;
    assign pop_data_o  = w_dp_data;
    assign pop_strb_o  = w_dp_strb;
    assign done_o      = r_done_zero | (w_dp_fire & w_dp_last);
    assign busy_o      = (r_state != S_IDLE);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_realign   <= 1'b0;
            r_off       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_res_data  <= '0;
            r_res_strb  <= '0;
            r_done_zero <= 1'b0;
        end else begin
            r_done_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i && w_start_ok) begin
                        if (line_length_i != '0) begin
                            r_realign <= realign_i;
                            r_off     <= offset_i;
                            r_len     <= line_length_i;
                            r_cnt     <= '0;
                            r_state   <= S_FIRST;
                        end else begin
                            r_done_zero <= 1'b1;
                        end
                    end
                end
                S_FIRST, S_MID: begin
                    if (w_dp_fire) begin
                        r_res_data <= push_data_i;
                        r_res_strb <= push_strb_i;
                        r_cnt      <= r_cnt + LEN_WIDTH'(1);
                        if (w_last_in) begin
                            r_state <= (w_koff != '0) ? S_FLUSH : S_IDLE;
                        end else begin
                            r_state <= S_MID;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_dp_fire) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_sink_byte_realign.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwpe_stream_sink_byte_realign
// Brief    : Directed self-checking bench for the sink byte realigner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwpe_stream_sink_byte_realign;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        realign;
    logic [1:0]  offset;
    logic [15:0] len;
    logic [31:0] push_data;
    logic [3:0]  push_strb;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] pop_data;
    logic [3:0]  pop_strb;
    logic        pop_valid;
    logic        pop_ready;
    logic        busy;
    logic        done;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] vin   [8];
    logic [31:0] exp_d [8];
    logic [3:0]  exp_s [8];
    logic [31:0] got_d [$];
    logic [3:0]  got_s [$];
    int          done_cnt;
    int          done_idx;
    logic        flush_bad;

    always #5 clk = ~clk;

    hwpe_stream_sink_byte_realign #(
        .DATA_WIDTH (32),
        .LEN_WIDTH  (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .realign_i     (realign),
        .offset_i      (offset),
        .line_length_i (len),
        .push_data_i   (push_data),
        .push_strb_i   (push_strb),
        .push_valid_i  (push_valid),
        .push_ready_o  (push_ready),
        .pop_data_o    (pop_data),
        .pop_strb_o    (pop_strb),
        .pop_valid_o   (pop_valid),
        .pop_ready_i   (pop_ready),
        .busy_o        (busy),
        .done_o        (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Drives one line; inputs change 1 time unit after posedge, outputs are sampled on negedge
    task automatic run_line(input logic re, input logic [1:0] off, input int n,
                            input bit stall, input int budget);
        int idx;
        int cyc;
        int tail;
        got_d.delete();
        got_s.delete();
        done_cnt  = 0;
        done_idx  = -1;
        flush_bad = 1'b0;
        idx       = 0;
        @(posedge clk); #1;
        start = 1'b1; realign = re; offset = off; len = n[15:0];
        push_valid = 1'b0; pop_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc  = 0;
        tail = 0;
        while (cyc < budget && tail < 3) begin
            pop_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            push_valid = (idx < n) && (!stall || ($urandom_range(0, 3) != 0));
            push_data  = (idx < 8) ? vin[idx] : 32'h11223344;
            push_strb  = 4'hF;
            @(negedge clk);
            if (pop_valid && pop_ready) begin
                got_d.push_back(pop_data);
                got_s.push_back(pop_strb);
            end
            if (done) begin
                done_cnt++;
                done_idx = got_d.size();
            end
            if (idx == n && push_ready) flush_bad = 1'b1;
            if (push_valid && push_ready) idx++;
            if (done_cnt > 0) tail++;
            cyc++;
            @(posedge clk); #1;
        end
        push_valid = 1'b0;
        pop_ready  = 1'b1;
    endtask

    task automatic check_line(input string name, input int cnt);
        chk($sformatf("%s_count", name), 64'(got_d.size()), 64'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (i < got_d.size()) begin
                chk($sformatf("%s_data%0d", name, i), 64'(got_d[i]), 64'(exp_d[i]));
                chk($sformatf("%s_strb%0d", name, i), 64'(got_s[i]), 64'(exp_s[i]));
            end
        end
        chk($sformatf("%s_done_cnt", name), 64'(done_cnt), 64'd1);
        chk($sformatf("%s_done_at", name), 64'(done_idx), 64'(cnt));
        chk($sformatf("%s_flush_ready", name), 64'(flush_bad), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dn;
        rst = 1'b1; start = 1'b0; realign = 1'b0; offset = 2'd0; len = 16'd0;
        push_data = 32'hFFFFFFFF; push_strb = 4'hF; push_valid = 1'b1; pop_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pop_valid",  64'(pop_valid),  64'd0);
        chk("rst_push_ready", 64'(push_ready), 64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_done",       64'(done),       64'd0);
        chk("rst_pop_data",   64'(pop_data),   64'd0);
        chk("rst_pop_strb",   64'(pop_strb),   64'd0);
        @(posedge clk); #1;
        rst = 1'b0; push_valid = 1'b0;

        // k=1, N=2
        vin[0] = 32'h44332211; vin[1] = 32'h88776655;
        exp_d[0] = 32'h33221100; exp_s[0] = 4'hE;
        exp_d[1] = 32'h77665544; exp_s[1] = 4'hF;
        exp_d[2] = 32'h00000088; exp_s[2] = 4'h1;
        run_line(1'b1, 2'd1, 2, 1'b0, 50);
        check_line("k1n2", 3);

        // realign off: offset ignored, pure pass-through
        vin[0] = 32'hA0A0A0A0; vin[1] = 32'hB1B1B1B1; vin[2] = 32'hC2C2C2C2;
        for (int i = 0; i < 3; i++) begin
            exp_d[i] = vin[i];
            exp_s[i] = 4'hF;
        end
        run_line(1'b0, 2'd1, 3, 1'b0, 50);
        check_line("pass", 3);

        // k=3, N=1: single word then flush
        vin[0] = 32'hDDCCBBAA;
        exp_d[0] = 32'hAA000000; exp_s[0] = 4'h8;
        exp_d[1] = 32'h00DDCCBB; exp_s[1] = 4'h7;
        run_line(1'b1, 2'd3, 1, 1'b0, 50);
        check_line("k3n1", 2);

        // k=2, N=4 under random backpressure and input gaps
        vin[0] = 32'h13121110; vin[1] = 32'h17161514;
        vin[2] = 32'h1B1A1918; vin[3] = 32'h1F1E1D1C;
        exp_d[0] = 32'h11100000; exp_s[0] = 4'hC;
        exp_d[1] = 32'h15141312; exp_s[1] = 4'hF;
        exp_d[2] = 32'h19181716; exp_s[2] = 4'hF;
        exp_d[3] = 32'h1D1C1B1A; exp_s[3] = 4'hF;
        exp_d[4] = 32'h00001F1E; exp_s[4] = 4'h3;
        run_line(1'b1, 2'd2, 4, 1'b1, 400);
        check_line("k2n4_stall", 5);

        // Reset in the middle of a k=1, N=4 line
        @(posedge clk); #1;
        start = 1'b1; realign = 1'b1; offset = 2'd1; len = 16'd4;
        @(posedge clk); #1;
        start = 1'b0; push_valid = 1'b1; pop_ready = 1'b1; push_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        push_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_pop_valid",  64'(pop_valid),  64'd0);
        chk("abort_busy",       64'(busy),       64'd0);
        chk("abort_push_ready", 64'(push_ready), 64'd0);
        dn = done ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'd0);
        push_valid = 1'b0;

        vin[0] = 32'h44332211; vin[1] = 32'h88776655;
        exp_d[0] = 32'h33221100; exp_s[0] = 4'hE;
        exp_d[1] = 32'h77665544; exp_s[1] = 4'hF;
        exp_d[2] = 32'h00000088; exp_s[2] = 4'h1;
        run_line(1'b1, 2'd1, 2, 1'b0, 50);
        check_line("after_abort", 3);

        // Zero-length line
        @(posedge clk); #1;
        start = 1'b1; realign = 1'b1; offset = 2'd2; len = 16'd0;
        @(negedge clk);
        chk("zero_busy0", 64'(busy), 64'd0);
        chk("zero_done0", 64'(done), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_done1",  64'(done),      64'd1);
        chk("zero_busy1",  64'(busy),      64'd0);
        chk("zero_pvalid", 64'(pop_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_done2", 64'(done), 64'd0);

        // Longest line: counter must not wrap
        for (int i = 0; i < 8; i++) vin[i] = 32'h11223344;
        run_line(1'b1, 2'd1, 65535, 1'b0, 66000);
        chk("maxlen_count", 64'(got_d.size()), 64'd65536);
        if (got_d.size() > 0) begin
            chk("maxlen_flush_data", 64'(got_d[got_d.size()-1]), 64'h00000011);
            chk("maxlen_flush_strb", 64'(got_s[got_s.size()-1]), 64'h1);
        end
        chk("maxlen_done_cnt", 64'(done_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
